// File: rtl/uart_rx_buf_ctrl_if.sv
// uart_rx_buf_ctrl_if: RX frame, config, stream and status signals of uart_rx_buf_ctrl.
// The slave modport is the buffer controller; the master modport is its environment.
interface uart_rx_buf_ctrl_if #(
   parameter int DEPTH     = 4,
   parameter int ERR_CNT_W = 8
);
   localparam int LW = $clog2(DEPTH) + 1;
   logic                 rx_valid;
   logic [7:0]           rx_data;
   logic                 rx_par_err;
   logic                 rx_stop_err;
   logic                 rx_busy;
   logic                 cfg_wr;
   logic                 cfg_parity_en;
   logic                 cfg_parity_type;
   logic                 parity_en;
   logic                 parity_type;
   logic                 cfg_pend;
   logic [7:0]           m_data;
   logic [1:0]           m_err;
   logic                 m_valid;
   logic                 m_ready;
   logic [LW-1:0]        level;
   logic                 overrun;
   logic                 clr_ovr;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 clr_cnt;

   modport slave (
      input  rx_valid, rx_data, rx_par_err, rx_stop_err, rx_busy,
      input  cfg_wr, cfg_parity_en, cfg_parity_type, m_ready, clr_ovr, clr_cnt,
      output parity_en, parity_type, cfg_pend, m_data, m_err, m_valid, level, overrun, err_cnt
   );

   modport master (
      output rx_valid, rx_data, rx_par_err, rx_stop_err, rx_busy,
      output cfg_wr, cfg_parity_en, cfg_parity_type, m_ready, clr_ovr, clr_cnt,
      input  parity_en, parity_type, cfg_pend, m_data, m_err, m_valid, level, overrun, err_cnt
   );
endinterface

// File: rtl/uart_rx_buf_ctrl.sv
// uart_rx_buf_ctrl: buffers received bytes with their error flags in a FIFO stream,
// keeps overrun/error-count status and applies parity config only between frames.
module uart_rx_buf_ctrl #(
   parameter int DEPTH     = 4,
   parameter int ERR_CNT_W = 8,
   parameter bit DROP_ERR  = 1'b0
) (
   input logic               clk2,
   input logic               rst,
   uart_rx_buf_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {S_IDLE, S_PEND} state_t;
   state_t               r_state;
   logic [9:0]           r_mem [DEPTH];
   logic [AW:0]          r_wr_ptr, r_rd_ptr;
   logic                 r_par_en, r_par_type, r_sh_en, r_sh_type, r_pend, r_ovr;
   logic [ERR_CNT_W-1:0] r_cnt;
   logic                 w_err, w_empty, w_full, w_pop, w_store, w_push, w_lost;

   assign w_err   = bus.rx_par_err | bus.rx_stop_err;
   assign w_empty = r_wr_ptr == r_rd_ptr;
   assign w_full  = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
   assign w_pop   = ~w_empty & bus.m_ready;
   assign w_store = bus.rx_valid & ~(DROP_ERR & w_err);
   // a pop frees the slot in the same edge, so a full FIFO still accepts
   assign w_push  = w_store & (~w_full | w_pop);
   assign w_lost  = w_store & w_full & ~w_pop;

   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {bus.rx_stop_err, bus.rx_par_err, bus.rx_data};
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         r_ovr <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_ovr <= w_lost | (r_ovr & ~bus.clr_ovr);
         if (bus.clr_cnt) r_cnt <= '0;
         else if (bus.rx_valid & w_err & ~&r_cnt) r_cnt <= r_cnt + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_pend     <= 1'b0;
         r_par_en   <= 1'b0;
         r_par_type <= 1'b0;
         r_sh_en    <= 1'b0;
         r_sh_type  <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (bus.cfg_wr & bus.rx_busy) begin
            r_sh_en   <= bus.cfg_parity_en;
            r_sh_type <= bus.cfg_parity_type;
            r_state   <= S_PEND;
            r_pend    <= 1'b1;
         end else if (bus.cfg_wr) begin
            r_par_en   <= bus.cfg_parity_en;
            r_par_type <= bus.cfg_parity_type;
         end
      end else if (!bus.rx_busy) begin
         r_par_en   <= bus.cfg_wr ? bus.cfg_parity_en : r_sh_en;
         r_par_type <= bus.cfg_wr ? bus.cfg_parity_type : r_sh_type;
         r_state    <= S_IDLE;
         r_pend     <= 1'b0;
      end else if (bus.cfg_wr) begin
         r_sh_en   <= bus.cfg_parity_en;
         r_sh_type <= bus.cfg_parity_type;
      end
   end

   assign bus.m_data      = r_mem[r_rd_ptr[AW-1:0]][7:0];
   assign bus.m_err       = r_mem[r_rd_ptr[AW-1:0]][9:8];
   assign bus.m_valid     = ~w_empty;
   assign bus.level       = r_wr_ptr - r_rd_ptr;
   assign bus.overrun     = r_ovr;
   assign bus.err_cnt     = r_cnt;
   assign bus.parity_en   = r_par_en;
   assign bus.parity_type = r_par_type;
   assign bus.cfg_pend    = r_pend;
endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// tb_uart_rx_buf_ctrl: three instances (plain, DROP_ERR=1, ERR_CNT_W=2) share one stimulus
// and are compared each cycle against a queue-level model, plus literal spot checks.
module tb_uart_rx_buf_ctrl;
   logic clk2 = 1'b0, rst = 1'b0, chk_on = 1'b0;
   logic rx_valid = 0, rx_par_err = 0, rx_stop_err = 0, rx_busy = 0;
   logic cfg_wr = 0, cfg_en = 0, cfg_type = 0, m_ready = 0, clr_ovr = 0, clr_cnt = 0;
   logic [7:0] rx_data = 0;
   int n_chk = 0, n_fail = 0;

   uart_rx_buf_ctrl_if #(.DEPTH(4), .ERR_CNT_W(8)) b0 ();
   uart_rx_buf_ctrl_if #(.DEPTH(4), .ERR_CNT_W(8)) b1 ();
   uart_rx_buf_ctrl_if #(.DEPTH(4), .ERR_CNT_W(2)) b2 ();

   uart_rx_buf_ctrl #(.DEPTH(4), .ERR_CNT_W(8), .DROP_ERR(1'b0)) d0 (.clk2(clk2), .rst(rst), .bus(b0.slave));
   uart_rx_buf_ctrl #(.DEPTH(4), .ERR_CNT_W(8), .DROP_ERR(1'b1)) d1 (.clk2(clk2), .rst(rst), .bus(b1.slave));
   uart_rx_buf_ctrl #(.DEPTH(4), .ERR_CNT_W(2), .DROP_ERR(1'b0)) d2 (.clk2(clk2), .rst(rst), .bus(b2.slave));

   assign b0.rx_valid = rx_valid; assign b0.rx_data = rx_data; assign b0.rx_par_err = rx_par_err;
   assign b0.rx_stop_err = rx_stop_err; assign b0.rx_busy = rx_busy; assign b0.cfg_wr = cfg_wr;
   assign b0.cfg_parity_en = cfg_en; assign b0.cfg_parity_type = cfg_type; assign b0.m_ready = m_ready;
   assign b0.clr_ovr = clr_ovr; assign b0.clr_cnt = clr_cnt;
   assign b1.rx_valid = rx_valid; assign b1.rx_data = rx_data; assign b1.rx_par_err = rx_par_err;
   assign b1.rx_stop_err = rx_stop_err; assign b1.rx_busy = rx_busy; assign b1.cfg_wr = cfg_wr;
   assign b1.cfg_parity_en = cfg_en; assign b1.cfg_parity_type = cfg_type; assign b1.m_ready = m_ready;
   assign b1.clr_ovr = clr_ovr; assign b1.clr_cnt = clr_cnt;
   assign b2.rx_valid = rx_valid; assign b2.rx_data = rx_data; assign b2.rx_par_err = rx_par_err;
   assign b2.rx_stop_err = rx_stop_err; assign b2.rx_busy = rx_busy; assign b2.cfg_wr = cfg_wr;
   assign b2.cfg_parity_en = cfg_en; assign b2.cfg_parity_type = cfg_type; assign b2.m_ready = m_ready;
   assign b2.clr_ovr = clr_ovr; assign b2.clr_cnt = clr_cnt;

   logic [7:0] o_data [3], o_cnt [3];
   logic [1:0] o_err [3];
   logic [2:0] o_level [3];
   logic       o_valid [3], o_ovr [3], o_pen [3], o_pty [3], o_pend [3];
   assign o_data[0] = b0.m_data; assign o_err[0] = b0.m_err; assign o_valid[0] = b0.m_valid;
   assign o_level[0] = b0.level; assign o_ovr[0] = b0.overrun; assign o_cnt[0] = b0.err_cnt;
   assign o_pen[0] = b0.parity_en; assign o_pty[0] = b0.parity_type; assign o_pend[0] = b0.cfg_pend;
   assign o_data[1] = b1.m_data; assign o_err[1] = b1.m_err; assign o_valid[1] = b1.m_valid;
   assign o_level[1] = b1.level; assign o_ovr[1] = b1.overrun; assign o_cnt[1] = b1.err_cnt;
   assign o_pen[1] = b1.parity_en; assign o_pty[1] = b1.parity_type; assign o_pend[1] = b1.cfg_pend;
   assign o_data[2] = b2.m_data; assign o_err[2] = b2.m_err; assign o_valid[2] = b2.m_valid;
   assign o_level[2] = b2.level; assign o_ovr[2] = b2.overrun; assign o_cnt[2] = {6'b0, b2.err_cnt};
   assign o_pen[2] = b2.parity_en; assign o_pty[2] = b2.parity_type; assign o_pend[2] = b2.cfg_pend;

   always #5 clk2 = ~clk2;

   // Model: per-instance FIFO contents as an array + size, counters as plain ints.
   int         DROP [3] = '{0, 1, 0};
   int         CMAX [3] = '{255, 255, 3};
   logic [9:0] mq [3][4];
   int         msz [3], mcnt [3];
   bit         movr [3];
   bit         m_pen, m_pty, m_want, m_sen, m_sty, lost, e;

   always @(posedge clk2 or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin msz[i] = 0; mcnt[i] = 0; movr[i] = 0; end
         m_pen = 0; m_pty = 0; m_want = 0; m_sen = 0; m_sty = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (msz[i] > 0 && m_ready) begin
               for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
               msz[i]--;
            end
            e = rx_par_err | rx_stop_err;
            lost = 0;
            if (rx_valid && !(DROP[i] != 0 && e)) begin
               if (msz[i] < 4) begin mq[i][msz[i]] = {rx_stop_err, rx_par_err, rx_data}; msz[i]++; end
               else lost = 1;
            end
            if (clr_cnt) mcnt[i] = 0;
            else if (rx_valid && e && mcnt[i] < CMAX[i]) mcnt[i]++;
            movr[i] = lost || (movr[i] && !clr_ovr);
         end
         if (cfg_wr) begin m_sen = cfg_en; m_sty = cfg_type; m_want = 1; end
         if (m_want && !rx_busy) begin m_pen = m_sen; m_pty = m_sty; m_want = 0; end
      end
   end

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
      end
   endtask

   always @(negedge clk2) begin
      if (chk_on) begin
         for (int i = 0; i < 3; i++) begin
            chk("m_valid", i, o_valid[i], msz[i] != 0);
            if (msz[i] != 0) begin
               chk("m_data", i, o_data[i], mq[i][0][7:0]);
               chk("m_err", i, o_err[i], mq[i][0][9:8]);
            end
            chk("level", i, o_level[i], msz[i]);
            chk("overrun", i, o_ovr[i], movr[i]);
            chk("err_cnt", i, o_cnt[i], mcnt[i]);
            chk("parity_en", i, o_pen[i], m_pen);
            chk("parity_type", i, o_pty[i], m_pty);
            chk("cfg_pend", i, o_pend[i], m_want);
         end
      end
   end

   task automatic cyc();
      @(posedge clk2);
      #1;
   endtask

   task automatic frame(input logic [7:0] d, input logic p, input logic s);
      rx_valid = 1; rx_data = d; rx_par_err = p; rx_stop_err = s;
      cyc();
      rx_valid = 0; rx_par_err = 0; rx_stop_err = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_m_valid"}, 0, b0.m_valid, 0);
      chk({tag, "_m_data"}, 0, b0.m_data, 0);
      chk({tag, "_m_err"}, 0, b0.m_err, 0);
      chk({tag, "_level"}, 0, b0.level, 0);
      chk({tag, "_overrun"}, 0, b0.overrun, 0);
      chk({tag, "_err_cnt"}, 0, b0.err_cnt, 0);
      chk({tag, "_parity_en"}, 0, b0.parity_en, 0);
      chk({tag, "_parity_type"}, 0, b0.parity_type, 0);
      chk({tag, "_cfg_pend"}, 0, b0.cfg_pend, 0);
   endtask

   initial begin
      repeat (2) cyc();
      chk_reset("rst");
      rst = 1; chk_on = 1;
      cyc();
      // single byte, consumer always ready
      m_ready = 1;
      frame(8'hA5, 0, 0);
      chk("first_valid", 0, b0.m_valid, 1);
      chk("first_data", 0, b0.m_data, 8'hA5);
      chk("first_err", 0, b0.m_err, 2'b00);
      cyc();
      chk("first_drained", 0, b0.level, 0);
      // overflow: fifth frame lost
      m_ready = 0;
      for (int i = 1; i <= 5; i++) frame(8'(i), 0, 0);
      chk("full_level", 0, b0.level, 4);
      chk("ovr_set", 0, b0.overrun, 1);
      m_ready = 1;
      for (int i = 1; i <= 4; i++) begin chk("drain_order", 0, b0.m_data, i); cyc(); end
      m_ready = 0;
      clr_ovr = 1; cyc(); clr_ovr = 0;
      chk("ovr_clr", 0, b0.overrun, 0);
      // full with simultaneous write and pop
      for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 0, 0);
      m_ready = 1;
      frame(8'h14, 0, 0);
      m_ready = 0;
      chk("fullpop_level", 0, b0.level, 4);
      chk("fullpop_ovr", 0, b0.overrun, 0);
      m_ready = 1;
      for (int i = 1; i <= 4; i++) begin chk("fullpop_order", 0, b0.m_data, 8'h10 + 8'(i)); cyc(); end
      m_ready = 0;
      // error frames
      for (int i = 0; i < 3; i++) frame(8'h21, 1, 0);
      frame(8'h22, 0, 1);
      chk("errcnt4", 0, b0.err_cnt, 4);
      chk("drop_errcnt4", 1, b1.err_cnt, 4);
      chk("drop_level0", 1, b1.level, 0);
      chk("sat_errcnt", 2, b2.err_cnt, 3);
      m_ready = 1;
      for (int i = 0; i < 3; i++) begin chk("m_err_par", 0, b0.m_err, 2'b01); cyc(); end
      chk("m_err_stop", 0, b0.m_err, 2'b10); cyc();
      m_ready = 0;
      frame(8'h23, 1, 1);
      chk("sat_errcnt5", 2, b2.err_cnt, 3);
      chk("errcnt5", 0, b0.err_cnt, 5);
      clr_cnt = 1; frame(8'h24, 1, 0); clr_cnt = 0;
      chk("clr_cnt_prio", 0, b0.err_cnt, 0);
      m_ready = 1; repeat (3) cyc(); m_ready = 0;
      // overrun set wins over clear
      for (int i = 0; i < 4; i++) frame(8'h30 + 8'(i), 0, 0);
      clr_ovr = 1; frame(8'h34, 0, 0); clr_ovr = 0;
      chk("ovr_set_prio", 0, b0.overrun, 1);
      clr_ovr = 1; cyc(); clr_ovr = 0;
      m_ready = 1; repeat (4) cyc(); m_ready = 0;
      // config while busy: last write wins, applied when busy drops
      rx_busy = 1;
      cfg_wr = 1; cfg_en = 1; cfg_type = 1; cyc();
      cfg_en = 1; cfg_type = 0; cyc();
      cfg_wr = 0;
      chk("pend_set", 0, b0.cfg_pend, 1);
      chk("pend_pen_hold", 0, b0.parity_en, 0);
      cyc();
      chk("pend_pty_hold", 0, b0.parity_type, 0);
      rx_busy = 0; cyc();
      chk("apply_pen", 0, b0.parity_en, 1);
      chk("apply_pty", 0, b0.parity_type, 0);
      chk("apply_pend", 0, b0.cfg_pend, 0);
      cfg_wr = 1; cfg_en = 0; cfg_type = 1; cyc(); cfg_wr = 0;
      chk("idle_pen", 0, b0.parity_en, 0);
      chk("idle_pty", 0, b0.parity_type, 1);
      // async reset mid-frame with stored data and a pending config
      frame(8'h61, 1, 0); frame(8'h62, 0, 0); frame(8'h63, 0, 0);
      rx_busy = 1; cfg_wr = 1; cfg_en = 1; cfg_type = 1; cyc(); cfg_wr = 0;
      chk("pre_rst_level", 0, b0.level, 3);
      chk("pre_rst_pend", 0, b0.cfg_pend, 1);
      #2 rst = 0;
      #1 chk_reset("async");
      cyc();
      rst = 1; rx_busy = 0;
      cyc();
      frame(8'h77, 0, 0);
      chk("post_rst_data", 0, b0.m_data, 8'h77);
      chk("post_rst_level", 0, b0.level, 1);
      m_ready = 1; cyc(); m_ready = 0;
      chk("post_rst_empty", 0, b0.m_valid, 0);
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_buf_ctrl.md
Name: uart_rx_buf_ctrl

Overview:
- Sits between uart_rx_top and the consuming logic. Captures each received byte and its error flags into a DEPTH-entry FIFO.
- Presents captured bytes on a valid/ready stream.
- Owns the RX configuration (parity_en/parity_type); a new configuration is applied only while no frame is in progress.
- Keeps overrun and error-count status.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
ERR_CNT_W, 8, width of saturating error counter
DROP_ERR, 0, 1 = frames with any error flag are counted but not stored

Ports:
clk2  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous reset, active-low
rx_valid  input  1  one-cycle pulse from RX: frame complete
rx_data  input  8  received byte, valid with rx_valid
rx_par_err  input  1  parity error for this frame, valid with rx_valid
rx_stop_err  input  1  stop-bit error for this frame, valid with rx_valid
rx_busy  input  1  RX is mid-frame (start bit detected, stop not yet done)
cfg_wr  input  1  request new configuration
cfg_parity_en  input  1  requested parity enable
cfg_parity_type  input  1  requested parity type (0 even, 1 odd)
parity_en  output  1  applied parity enable to RX
parity_type  output  1  applied parity type to RX
cfg_pend  output  1  a cfg_wr is waiting to be applied
m_data  output  8  head-of-FIFO byte
m_err  output  2  {stop_err, par_err} of head entry
m_valid  output  1  head entry valid
m_ready  input  1  consumer accepts head when m_valid & m_ready
level  output  $clog2(DEPTH)+1  number of stored entries
overrun  output  1  sticky: a frame was lost because the FIFO was full
clr_ovr  input  1  clears overrun
err_cnt  output  ERR_CNT_W  saturating count of frames with any error
clr_cnt  input  1  clears err_cnt

Behaviour:
Reset (rst low, async):
- Outputs: parity_en=0, parity_type=0, cfg_pend=0, m_valid=0, m_data=0, m_err=0, level=0, overrun=0, err_cnt=0.
- Pointers zeroed; any stored entries discarded.
- A reset mid-frame or with a full FIFO loses everything; no partial state survives.

FIFO:
- Write: on rx_valid, entry {rx_stop_err, rx_par_err, rx_data}. Not stored when DROP_ERR=1 and either error flag is set.
- Read: m_valid & m_ready pops the head.
- m_data, m_err and m_valid come straight from head storage and level/empty state. No output register.
- Latency: rx_valid at cycle N gives m_valid=1 at N+1 when the FIFO was empty.
- Pointers: $clog2(DEPTH)+1 bits each; wrap modulo 2*DEPTH.
  - full = pointers differ only in MSB.
  - empty = pointers equal.
  - level = wr_ptr - rd_ptr.
- Full, with rx_valid and a pop in the same cycle: the write is accepted; level stays DEPTH; no overrun.
- Full, with rx_valid and no pop: the frame is dropped and overrun is set at the next edge.
- Empty, with rx_valid and m_ready: no bypass. The byte appears at N+1.
- m_data/m_err hold stable while m_valid=1 and m_ready=0.

Status:
- overrun: set has priority over clr_ovr in the same cycle.
- err_cnt: +1 on rx_valid with (rx_par_err | rx_stop_err), regardless of DROP_ERR or full.
  - Saturates at all-ones.
  - clr_cnt has priority over increment.

Config sequencer, 2 states:
- IDLE: cfg_pend=0.
  - If cfg_wr & !rx_busy: load parity_en/parity_type at the next edge; stay in IDLE.
  - If cfg_wr & rx_busy: latch request into shadow; go to PEND.
- PEND: cfg_pend=1.
  - A further cfg_wr overwrites the shadow (last write wins).
  - On the first cycle with rx_busy=0: apply the shadow (or the concurrent cfg_wr value, if present) at the next edge; go to IDLE.
- parity_en/parity_type never change while rx_busy=1.

Test Plan:
- Reset then write 0xA5 (no errors), m_ready=1 -> m_valid=1 one cycle after rx_valid, m_data=0xA5, m_err=00, level returns to 0.
- m_ready=0, push 0x01..0x05 with DEPTH=4 -> level=4, 5th frame lost, overrun=1. Drain -> 0x01,0x02,0x03,0x04 in order. Pulse clr_ovr -> overrun=0.
- Full FIFO, rx_valid and pop in the same cycle -> level stays 4, overrun stays 0, new byte read out last.
- 3 frames with rx_par_err=1 and 1 with rx_stop_err=1 -> err_cnt=4, m_err=01,01,01,10. Repeat with DROP_ERR=1 -> err_cnt=4, level=0. With ERR_CNT_W=2, drive 5 errors -> err_cnt=3.
- rx_busy=1, cfg_wr with {1,1}, then cfg_wr with {1,0} -> cfg_pend=1, parity_en/parity_type unchanged. rx_busy falls -> next edge parity_en=1, parity_type=0, cfg_pend=0.
- Assert rst mid-frame with level=3 and cfg_pend=1 -> all outputs reset immediately (async). After release, the next rx_valid byte is the first read out.
